// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Decode-stage interlock controller for the 5-stage RV32I pipeline. It tracks
// in-flight destination registers in a scoreboard. Each cycle it decides
// whether the decode instruction issues, stalls fetch/decode, or is squashed
// by a branch redirect.
// Optional feature: define FORWARDING_EN to let a RAW hazard on the most
// recently issued non-load result proceed. The forwarded source is reported
// on the fwd_rs1/fwd_rs2 ports.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN_REGS    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_rd_write_enable,
  input  logic [4:0]           id_rd_addr,
  input  logic                 id_res_src,
  input  logic                 ex_ready,
  input  logic                 ex_redirect,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  output logic                 issue,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic [XLEN_REGS-1:0] busy_vec,
  output logic [31:0]          stall_count
`ifdef FORWARDING_EN
  ,
  output logic                 fwd_rs1,
  output logic                 fwd_rs2
`endif
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]           state;
  logic [2:0]           flush_cnt;
  logic [XLEN_REGS-1:0] busy_next;
  logic                 src1_busy, src2_busy, rd_busy;
  logic                 src1_fwd, src2_fwd;
  logic                 hazard;

`ifdef FORWARDING_EN
  logic       last_valid;
  logic [4:0] last_rd;
  logic       last_load;

  // A busy source can bypass the scoreboard only if it is the last issued non-load result
  always_comb begin
    src1_fwd = src1_busy && last_valid && (id_rs1_addr == last_rd) && !last_load;
    src2_fwd = src2_busy && last_valid && (id_rs2_addr == last_rd) && !last_load;
    fwd_rs1  = issue && src1_fwd;
    fwd_rs2  = issue && src2_fwd;
  end

  // Remember the last issued destination; a stalled cycle lets a load result mature
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_rd    <= 5'd0;
      last_load  <= 1'b0;
    end else if (issue) begin
      last_valid <= id_rd_write_enable && (id_rd_addr != 5'd0);
      last_rd    <= id_rd_addr;
      last_load  <= id_res_src;
    end else begin
      last_load  <= 1'b0;
    end
  end
`else
  // Without forwarding every busy source waits for writeback
  always_comb begin
    src1_fwd = 1'b0;
    src2_fwd = 1'b0;
  end
`endif

  // Hazard detection and issue/stall/flush decisions; all forced low while in reset
  always_comb begin
    src1_busy = id_uses_rs1 && (id_rs1_addr != 5'd0) && busy_vec[id_rs1_addr];
    src2_busy = id_uses_rs2 && (id_rs2_addr != 5'd0) && busy_vec[id_rs2_addr];
    rd_busy   = id_rd_write_enable && (id_rd_addr != 5'd0) && busy_vec[id_rd_addr];
    hazard    = id_valid && ((src1_busy && !src1_fwd) || (src2_busy && !src2_fwd) || rd_busy);
    issue     = !rst && (state == RUN) && id_valid && !hazard && ex_ready && !ex_redirect;
    stall_id  = !rst && (state == RUN) && id_valid && !issue && !ex_redirect;
    stall_if  = stall_id;
    flush_id  = !rst && (ex_redirect || (flush_cnt != 3'd0));
  end

  // Next scoreboard: writeback clears first so a same-cycle issue set wins
  always_comb begin
    busy_next = busy_vec;
    if (wb_valid && (wb_addr != 5'd0))
      busy_next[wb_addr] = 1'b0;
    if (issue && id_rd_write_enable && (id_rd_addr != 5'd0))
      busy_next[id_rd_addr] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_vec <= '0;
    else
      busy_vec <= busy_next;
  end

  // RUN/FLUSH sequencing; a redirect (re)loads the flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else if (ex_redirect) begin
      state     <= FLUSH;
      flush_cnt <= 3'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      if (flush_cnt <= 3'd1) begin
        flush_cnt <= 3'd0;
        state     <= RUN;
      end else begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

  // Saturating count of decode stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= 32'd0;
    else if (stall_id && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard-driven bench for pipeline_hazard_ctrl. Expected values are queued
// when each cycle's stimulus is driven and popped when the outputs settle.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_rd_write_enable, id_res_src;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_addr;
  logic        ex_ready, ex_redirect, wb_valid;
  logic        issue, stall_if, stall_id, flush_id;
  logic [31:0] busy_vec, stall_count;
`ifdef FORWARDING_EN
  logic        fwd_rs1, fwd_rs2;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .XLEN_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_write_enable(id_rd_write_enable), .id_rd_addr(id_rd_addr),
    .id_res_src(id_res_src), .ex_ready(ex_ready), .ex_redirect(ex_redirect),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .busy_vec(busy_vec), .stall_count(stall_count)
`ifdef FORWARDING_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observe(input string tag);
    if (tag == "issue")       return {31'd0, issue};
    if (tag == "stall_id")    return {31'd0, stall_id};
    if (tag == "stall_if")    return {31'd0, stall_if};
    if (tag == "flush_id")    return {31'd0, flush_id};
    if (tag == "busy_vec")    return busy_vec;
    if (tag == "stall_count") return stall_count;
`ifdef FORWARDING_EN
    if (tag == "fwd_rs1")     return {31'd0, fwd_rs1};
    if (tag == "fwd_rs2")     return {31'd0, fwd_rs2};
`endif
    return 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic expectOut(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic expectCore(input logic iss, input logic stl, input logic fl,
                            input logic [31:0] busy, input logic [31:0] cnt);
    expectOut("issue", {31'd0, iss});
    expectOut("stall_id", {31'd0, stl});
    expectOut("stall_if", {31'd0, stl});
    expectOut("flush_id", {31'd0, fl});
    expectOut("busy_vec", busy);
    expectOut("stall_count", cnt);
  endtask

  task automatic drainChecks();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e.tag, observe(e.tag), e.value);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic we,
                               input logic [4:0] rd, input logic ld, input logic rdy,
                               input logic redir, input logic wbv, input logic [4:0] wba);
    @(negedge clk);
    id_valid = v;   id_rs1_addr = rs1; id_uses_rs1 = u1;
    id_rs2_addr = rs2; id_uses_rs2 = u2;
    id_rd_write_enable = we; id_rd_addr = rd; id_res_src = ld;
    ex_ready = rdy; ex_redirect = redir; wb_valid = wbv; wb_addr = wba;
  endtask

  task automatic settleAndCheck();
    #2;
    drainChecks();
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b1; id_rs1_addr = 5'd0; id_uses_rs1 = 1'b0;
    id_rs2_addr = 5'd0; id_uses_rs2 = 1'b0;
    id_rd_write_enable = 1'b0; id_rd_addr = 5'd0; id_res_src = 1'b0;
    ex_ready = 1'b1; ex_redirect = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0;
    $display("[TB] reset phase");
    repeat (2) @(negedge clk);
    #2;
    expectCore(0, 0, 0, 32'h0, 32'd0);
    drainChecks();
    id_valid = 1'b0; ex_redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] issue and RAW stall");
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 1, 5'd1, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h0,  0); settleAndCheck();
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h2,  0); settleAndCheck();
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h2,  1); settleAndCheck();
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 1, 0, 1, 5'd1); expectCore(0, 1, 0, 32'h2,  2); settleAndCheck();
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h0,  3); settleAndCheck();

    $display("[TB] set-wins and WAW");
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 1, 0, 1, 5'd5); expectCore(1, 0, 0, 32'h4,  3); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 1, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h24, 3); settleAndCheck();

    $display("[TB] redirect and flush");
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 1, 1, 1, 5'd2); expectCore(0, 0, 1, 32'h24, 4); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 1, 0, 0, 5'd0); expectCore(0, 0, 1, 32'h20, 4); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 1, 0, 0, 5'd0); expectCore(0, 0, 1, 32'h20, 4); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h20, 4); settleAndCheck();

    $display("[TB] rs2 stall then async reset");
    applyStimulus(1, 5'd0, 1, 5'd6, 1, 1, 5'd7, 0, 1, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h60, 4); settleAndCheck();
    rst = 1'b1;
    #1;
    expectCore(0, 0, 0, 32'h0, 32'd0);
    drainChecks();
    id_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] ex_ready low and redirect reload");
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h0, 0); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd0); expectCore(0, 0, 1, 32'h0, 1); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(0, 0, 1, 32'h0, 1); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd0); expectCore(0, 0, 1, 32'h0, 1); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(0, 0, 1, 32'h0, 1); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(0, 0, 1, 32'h0, 1); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h0, 1); settleAndCheck();

`ifdef FORWARDING_EN
    $display("[TB] forwarding");
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h0, 1); settleAndCheck();
    applyStimulus(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h8, 1);
    expectOut("fwd_rs1", 32'd1); expectOut("fwd_rs2", 32'd0); settleAndCheck();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 5'd3); expectCore(0, 0, 0, 32'h8, 1); settleAndCheck();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 1, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h0, 1); settleAndCheck();
    applyStimulus(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(0, 1, 0, 32'h8, 1);
    expectOut("fwd_rs1", 32'd0); settleAndCheck();
    applyStimulus(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0); expectCore(1, 0, 0, 32'h8, 2);
    expectOut("fwd_rs1", 32'd1); settleAndCheck();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
